// File: rtl/vm_clken_pkg.sv
// Shared types and constants for the clock-enable scheduler.
package vm_clken_pkg;

  localparam int NUM_CLK_MAX   = 4;
  localparam int MIN_PERIOD    = 2;
  localparam int CHAN_W        = $clog2(NUM_CLK_MAX);
  // Period field width of the pending slot; PERIOD_W must not exceed it.
  localparam int PEND_PERIOD_W = 16;

  typedef struct packed {
    logic [CHAN_W-1:0]        chan;
    logic [PEND_PERIOD_W-1:0] period;
    logic                     enable;
  } pend_upd_t;

  typedef enum logic [1:0] {
    IMMEDIATE,
    TERMINAL,
    SYNC
  } apply_reason_e;

endpackage

// File: rtl/vm_clken_chan.sv
// One scheduler channel: period/counter/run state, strobe decode, and the
// accept side of the apply handshake from the shared pending slot.
module vm_clken_chan
  import vm_clken_pkg::*;
#(
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sync,
  input  logic                apply_req,
  input  logic [PERIOD_W-1:0] apply_period,
  input  logic                apply_enable,
  output logic                apply_ack,
  output logic                clk_en,
  output logic                active,
  output logic [PERIOD_W-1:0] period
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] cnt;
  logic                at_term;
  apply_reason_e       reason;

  assign at_term = (cnt == '0);
  // Strobe decoded purely from registers so it is glitch-free.
  assign clk_en  = active & at_term;

  // Decide whether a pending update may land this cycle: immediately on an
  // idle channel, otherwise only at a period boundary (terminal count or sync).
  always_comb begin
    reason    = IMMEDIATE;
    apply_ack = 1'b0;
    if (apply_req) begin
      if (!active) begin
        reason    = IMMEDIATE;
        apply_ack = 1'b1;
      end else if (sync) begin
        reason    = SYNC;
        apply_ack = 1'b1;
      end else if (at_term) begin
        reason    = TERMINAL;
        apply_ack = 1'b1;
      end
    end
  end

  // Channel state: apply updates at boundaries, otherwise count down and reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      period <= PERIOD_W'(DEFAULT_PERIOD);
      cnt    <= '0;
      active <= 1'b0;
    end else if (apply_ack) begin
      case (reason)
        IMMEDIATE: begin
          if (apply_enable) begin
            period <= apply_period;
            cnt    <= apply_period - ONE;
            active <= 1'b1;
          end
        end
        TERMINAL, SYNC: begin
          if (apply_enable) begin
            period <= apply_period;
            cnt    <= apply_period - ONE;
          end else begin
            active <= 1'b0;
            cnt    <= '0;
          end
        end
        default: ;
      endcase
    end else if (active) begin
      if (sync || at_term) cnt <= period - ONE;
      else                 cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/vm_clken_sched.sv
// Clock-enable scheduler top: config handshake and validation, single pending
// update slot, sync fan-out, per-channel instances and period readback.
module vm_clken_sched
  import vm_clken_pkg::*;
#(
  parameter int NUM_CLK        = 4,
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic                cfg_enable,
  output logic                cfg_err,
  input  logic                sync_start,
  input  logic [CHAN_W-1:0]   rd_chan,
  output logic [PERIOD_W-1:0] rd_period,
  output logic [NUM_CLK-1:0]  clk_en,
  output logic [NUM_CLK-1:0]  chan_active
);

  pend_upd_t           pend;
  logic                pend_valid;
  logic                xfer;
  logic                reject;
  logic [PERIOD_W-1:0] pend_period;
  logic [NUM_CLK-1:0]  apply_req;
  logic [NUM_CLK-1:0]  apply_ack;
  logic [PERIOD_W-1:0] chan_period [NUM_CLK];

  assign cfg_ready   = ~pend_valid;
  assign xfer        = cfg_valid & cfg_ready;
  // Period is only meaningful when enabling; a stop request ignores it.
  assign reject      = (int'(cfg_chan) >= NUM_CLK) ||
                       (cfg_enable && (cfg_period < PERIOD_W'(MIN_PERIOD)));
  assign pend_period = pend.period[PERIOD_W-1:0];

  // Slot occupancy and error pulse; the slot frees on the owning channel's ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= xfer & reject;
      if (xfer && !reject)  pend_valid <= 1'b1;
      else if (|apply_ack)  pend_valid <= 1'b0;
    end
  end

  // Pending payload; qualified by pend_valid so it needs no reset.
  always_ff @(posedge clk) begin
    if (xfer && !reject) begin
      pend.chan   <= cfg_chan;
      pend.period <= PEND_PERIOD_W'(cfg_period);
      pend.enable <= cfg_enable;
    end
  end

  for (genvar i = 0; i < NUM_CLK; i++) begin : g_chan
    assign apply_req[i] = pend_valid && (int'(pend.chan) == i);

    vm_clken_chan #(
      .PERIOD_W       (PERIOD_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .sync         (sync_start),
      .apply_req    (apply_req[i]),
      .apply_period (pend_period),
      .apply_enable (pend.enable),
      .apply_ack    (apply_ack[i]),
      .clk_en       (clk_en[i]),
      .active       (chan_active[i]),
      .period       (chan_period[i])
    );
  end

  // Readback mux; unimplemented channels read as zero.
  always_comb begin
    rd_period = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      if (int'(rd_chan) == i) rd_period = chan_period[i];
    end
  end

endmodule

// File: tb/tb_vm_clken_sched.sv
// Scoreboard bench for vm_clken_sched with three channels (so channel 3 is
// out of range). Expected strobe and error edges are pushed into queues by the
// stimulus; a monitor pops and compares whenever the DUT raises clk_en/cfg_err.
// "edge n" below is the number of rising edges seen; outputs are sampled in the
// low phase after that edge.
module tb_vm_clken_sched;

  localparam int NUM_CLK        = 3;
  localparam int PERIOD_W       = 16;
  localparam int DEFAULT_PERIOD = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [1:0]          cfg_chan = '0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic                cfg_enable = 1'b0;
  logic                cfg_err;
  logic                sync_start = 1'b0;
  logic [1:0]          rd_chan = '0;
  logic [PERIOD_W-1:0] rd_period;
  logic [NUM_CLK-1:0]  clk_en;
  logic [NUM_CLK-1:0]  chan_active;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  int q_ch0[$];
  int q_ch1[$];
  int q_ch2[$];
  int q_err[$];

  vm_clken_sched #(
    .NUM_CLK        (NUM_CLK),
    .PERIOD_W       (PERIOD_W),
    .DEFAULT_PERIOD (DEFAULT_PERIOD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_period  (cfg_period),
    .cfg_enable  (cfg_enable),
    .cfg_err     (cfg_err),
    .sync_start  (sync_start),
    .rd_chan     (rd_chan),
    .rd_period   (rd_period),
    .clk_en      (clk_en),
    .chan_active (chan_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic rd_chk(input string name, input int ch, input int exp);
    rd_chan = ch[1:0];
    #1;
    chk(name, rd_period, exp);
  endtask

  task automatic push_strobe(input int ch, input int e);
    case (ch)
      0:       q_ch0.push_back(e);
      1:       q_ch1.push_back(e);
      default: q_ch2.push_back(e);
    endcase
  endtask

  task automatic push_run(input int ch, input int first, input int per, input int last);
    for (int e = first; e <= last; e += per) push_strobe(ch, e);
  endtask

  task automatic check_strobe(input int ch);
    int  e;
    bit  have;
    e    = 0;
    have = 1'b0;
    case (ch)
      0:       if (q_ch0.size() > 0) begin e = q_ch0.pop_front(); have = 1'b1; end
      1:       if (q_ch1.size() > 0) begin e = q_ch1.pop_front(); have = 1'b1; end
      default: if (q_ch2.size() > 0) begin e = q_ch2.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL strobe_ch%0d unexpected strobe at edge %0d, none required", ch, edge_n);
    end else if (e != edge_n) begin
      failures++;
      $display("FAIL strobe_ch%0d got strobe at edge %0d, required edge %0d", ch, edge_n, e);
    end
  endtask

  // Monitor: every strobe and every error pulse must match the next queued edge.
  always @(negedge clk) begin
    #1;
    for (int ch = 0; ch < NUM_CLK; ch++) begin
      if (clk_en[ch]) check_strobe(ch);
    end
    if (cfg_err) begin
      checks++;
      if (q_err.size() == 0) begin
        failures++;
        $display("FAIL cfg_err unexpected pulse at edge %0d, none required", edge_n);
      end else begin
        int e;
        e = q_err.pop_front();
        if (e != edge_n) begin
          failures++;
          $display("FAIL cfg_err got pulse at edge %0d, required edge %0d", edge_n, e);
        end
      end
    end
  end

  task automatic wait_edge(input int e);
    if (edge_n > e) begin
      checks++;
      failures++;
      $display("FAIL wait_edge already at edge %0d, required edge %0d", edge_n, e);
    end
    while (edge_n < e) @(negedge clk);
  endtask

  // Offer one config word; t returns the edge on which the transfer happened.
  task automatic cfg_write(input int ch, input int per, input logic en, output int t);
    int guard;
    guard      = 0;
    cfg_chan   = ch[1:0];
    cfg_period = per[PERIOD_W-1:0];
    cfg_enable = en;
    cfg_valid  = 1'b1;
    while (!cfg_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!cfg_ready) begin
      checks++;
      failures++;
      $display("FAIL cfg_ready_timeout got ready=0 for %0d cycles, required ready=1", guard);
      t         = edge_n;
      cfg_valid = 1'b0;
      return;
    end
    t = edge_n + 1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_clk_en", clk_en, 0);
    chk("rst_chan_active", chan_active, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    for (int c = 0; c < NUM_CLK; c++) rd_chk("rst_rd_period", c, DEFAULT_PERIOD);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got no finish by time %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int t, t2, a, b, s;
    @(negedge clk);
    do_reset();

    // Start ch0 at period 4, then retune to 7 mid-period.
    cfg_write(0, 4, 1'b1, t);
    push_run(0, t + 4, 4, t + 12);
    push_run(0, t + 19, 7, t + 29);
    chk("s1_active_before_apply", chan_active[0], 0);
    @(negedge clk);
    chk("s1_active_after_apply", chan_active[0], 1);
    chk("s1_ready_after_apply", cfg_ready, 1);
    rd_chk("s1_rd_period", 0, 4);
    wait_edge(t + 9);
    cfg_write(0, 7, 1'b1, t2);
    chk("s2_xfer_edge", t2, t + 10);
    chk("s2_ready_held_a", cfg_ready, 0);
    @(negedge clk);
    chk("s2_ready_held_b", cfg_ready, 0);
    @(negedge clk);
    chk("s2_ready_held_c", cfg_ready, 0);
    rd_chk("s2_rd_old_period", 0, 4);
    @(negedge clk);
    chk("s2_ready_back", cfg_ready, 1);
    rd_chk("s2_rd_new_period", 0, 7);
    wait_edge(t + 29);
    do_reset();

    // Stop ch1 (period 5) mid-period: last strobe still fires.
    cfg_write(1, 5, 1'b1, t);
    push_run(1, t + 5, 5, t + 10);
    wait_edge(t + 7);
    cfg_write(1, 0, 1'b0, t2);
    chk("s3_xfer_edge", t2, t + 8);
    wait_edge(t + 10);
    chk("s3_active_on_final", chan_active[1], 1);
    @(negedge clk);
    chk("s3_active_dropped", chan_active[1], 0);
    chk("s3_ready_back", cfg_ready, 1);
    wait_edge(t + 20);
    chk("s3_still_stopped", chan_active[1], 0);
    wait_edge(t + 24);
    do_reset();

    // Rejected configs: period below minimum, and out-of-range channel.
    cfg_write(0, 1, 1'b1, t);
    q_err.push_back(t);
    chk("s4_ready_after_short", cfg_ready, 1);
    chk("s4_active_after_short", chan_active, 0);
    rd_chk("s4_rd_unchanged", 0, DEFAULT_PERIOD);
    @(negedge clk);
    cfg_write(3, 20, 1'b1, t);
    q_err.push_back(t);
    chk("s4_ready_after_badchan", cfg_ready, 1);
    chk("s4_active_after_badchan", chan_active, 0);
    @(negedge clk);
    cfg_write(3, 0, 1'b0, t);
    q_err.push_back(t);
    chk("s4_ready_after_badchan_stop", cfg_ready, 1);
    @(negedge clk);
    cfg_write(2, 0, 1'b0, t);
    chk("s4_stop_idle_slot_taken", cfg_ready, 0);
    @(negedge clk);
    chk("s4_stop_idle_slot_freed", cfg_ready, 1);
    chk("s4_stop_idle_no_run", chan_active, 0);
    rd_chk("s4_rd_ch2_unchanged", 2, DEFAULT_PERIOD);
    rd_chk("s4_rd_out_of_range", 3, 0);
    do_reset();

    // ch0=3, ch2=5 then two syncs; the second lands a pending ch2 update.
    cfg_write(0, 3, 1'b1, a);
    cfg_write(2, 5, 1'b1, b);
    chk("s5_second_xfer_edge", b, a + 2);
    s = a + 20;
    push_run(0, a + 3, 3, a + 18);
    push_run(0, s + 2, 3, s + 11);
    push_run(0, s + 15, 3, s + 27);
    push_run(2, a + 7, 5, a + 17);
    push_run(2, s + 4, 5, s + 9);
    push_run(2, s + 18, 6, s + 24);
    wait_edge(s - 1);
    sync_start = 1'b1;
    @(negedge clk);
    sync_start = 1'b0;
    chk("s5_sync_cycle_no_strobe", clk_en, 0);
    chk("s5_ch1_untouched", chan_active, 5);
    wait_edge(s + 9);
    cfg_write(2, 6, 1'b1, t);
    chk("s5_pending_xfer_edge", t, s + 10);
    wait_edge(s + 12);
    sync_start = 1'b1;
    chk("s5_ready_before_sync", cfg_ready, 0);
    @(negedge clk);
    sync_start = 1'b0;
    chk("s5_ready_after_sync_apply", cfg_ready, 1);
    chk("s5_sync2_cycle_no_strobe", clk_en, 0);
    rd_chk("s5_rd_sync_applied", 2, 6);
    wait_edge(s + 27);
    do_reset();

    // Reset while an update is pending: it must be discarded.
    cfg_write(0, 8, 1'b1, t);
    wait_edge(t + 2);
    cfg_write(0, 3, 1'b1, t2);
    chk("s6_xfer_edge", t2, t + 3);
    chk("s6_pending_held", cfg_ready, 0);
    do_reset();
    repeat (20) @(negedge clk);
    chk("s6_stale_never_applied", chan_active, 0);
    chk("s6_ready_idle", cfg_ready, 1);
    rd_chk("s6_rd_default", 0, DEFAULT_PERIOD);

    chk("end_ch0_strobes_left", q_ch0.size(), 0);
    chk("end_ch1_strobes_left", q_ch1.size(), 0);
    chk("end_ch2_strobes_left", q_ch2.size(), 0);
    chk("end_err_left", q_err.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
